// File: rtl/tic_tac_toe_nxn.sv
// NxN, K-in-a-row game core: cursor, occupancy bitboards, turn, move count and win/draw.
// Win detection walks one direction per cycle through the most recently placed cell.
module tic_tac_toe_nxn #(
  parameter int N    = 3,
  parameter int K    = 3,
  parameter bit WRAP = 1'b1,
  localparam int CELLS = N * N,
  localparam int IW    = $clog2(CELLS),
  localparam int CW    = $clog2(CELLS + 1)
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             BtnL,
  input  logic             BtnR,
  input  logic             BtnU,
  input  logic             BtnD,
  input  logic             BtnC,
  output logic [IW-1:0]    I,
  output logic [CELLS-1:0] P1,
  output logic [CELLS-1:0] P2,
  output logic             Player,
  output logic             PlayerMoved,
  output logic             Invalid,
  output logic             Busy,
  output logic             P1Won,
  output logic             P2Won,
  output logic             Draw,
  output logic [CW-1:0]    MoveCount
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] CENTER = RW'(N / 2);
  localparam logic [RW-1:0] LAST   = RW'(N - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    row_q, row_d, col_q, col_d;
  logic [RW-1:0]    pr_q, pr_d, pc_q, pc_d;
  logic [CELLS-1:0] p1_q, p1_d, p2_q, p2_d;
  logic             player_q, player_d;
  logic             moved_q, moved_d;
  logic             invalid_q, invalid_d;
  logic             p1won_q, p1won_d, p2won_q, p2won_d;
  logic             draw_q, draw_d;
  logic             hit_q, hit_d;
  logic [1:0]       dir_q, dir_d;
  logic [CW-1:0]    moves_q, moves_d;

  logic [IW-1:0]    cur_idx;
  logic [CELLS-1:0] cur_mask;
  logic [CELLS-1:0] mover_board;
  logic [2:0]       btn_cnt;
  logic             one_btn;
  logic             run_hit;

  function automatic logic in_board(input int r, input int c);
    return (r >= 0) && (r < N) && (c >= 0) && (c < N);
  endfunction

  function automatic logic [IW-1:0] cell_index(input int r, input int c);
    return in_board(r, c) ? IW'(r * N + c) : '0;
  endfunction

  assign cur_idx     = IW'(row_q) * IW'(N) + IW'(col_q);
  assign cur_mask    = CELLS'(1) << cur_idx;
  assign mover_board = player_q ? p2_q : p1_q;
  assign btn_cnt     = 3'(BtnL) + 3'(BtnR) + 3'(BtnU) + 3'(BtnD) + 3'(BtnC);
  assign one_btn     = (btn_cnt == 3'd1);

  // Run length through the latched cell along the direction selected by dir_q; each
  // side stops at the first gap or board edge, so runs never wrap across edges.
  always_comb begin
    int   dr, dc, r, c, run;
    logic fwd_ok, bwd_ok;
    case (dir_q)
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      2'd3:    begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    run    = 1;
    fwd_ok = 1'b1;
    bwd_ok = 1'b1;
    for (int s = 1; s < K; s++) begin
      r = int'(pr_q) + s * dr;
      c = int'(pc_q) + s * dc;
      if (fwd_ok && in_board(r, c) && mover_board[cell_index(r, c)]) run = run + 1;
      else fwd_ok = 1'b0;
      r = int'(pr_q) - s * dr;
      c = int'(pc_q) - s * dc;
      if (bwd_ok && in_board(r, c) && mover_board[cell_index(r, c)]) run = run + 1;
      else bwd_ok = 1'b0;
    end
    run_hit = (run >= K);
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    player_d  = player_q;
    moved_d   = 1'b0;
    invalid_d = 1'b0;
    p1won_d   = p1won_q;
    p2won_d   = p2won_q;
    draw_d    = draw_q;
    hit_d     = hit_q;
    dir_d     = dir_q;
    moves_d   = moves_q;
    if (restart) begin
      state_d  = ST_IDLE;
      row_d    = CENTER;
      col_d    = CENTER;
      p1_d     = '0;
      p2_d     = '0;
      player_d = 1'b0;
      p1won_d  = 1'b0;
      p2won_d  = 1'b0;
      draw_d   = 1'b0;
      hit_d    = 1'b0;
      dir_d    = 2'd0;
      moves_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (one_btn) begin
            if (BtnL) col_d = (col_q != '0) ? col_q - RW'(1) : (WRAP ? LAST : col_q);
            if (BtnR) col_d = (col_q != LAST) ? col_q + RW'(1) : (WRAP ? '0 : col_q);
            if (BtnU) row_d = (row_q != '0) ? row_q - RW'(1) : (WRAP ? LAST : row_q);
            if (BtnD) row_d = (row_q != LAST) ? row_q + RW'(1) : (WRAP ? '0 : row_q);
            if (BtnC) begin
              if (((p1_q | p2_q) & cur_mask) != '0) begin
                invalid_d = 1'b1;
              end else begin
                if (player_q) p2_d = p2_q | cur_mask;
                else          p1_d = p1_q | cur_mask;
                moves_d = moves_q + CW'(1);
                moved_d = 1'b1;
                pr_d    = row_q;
                pc_d    = col_q;
                dir_d   = 2'd0;
                hit_d   = 1'b0;
                state_d = ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          hit_d = hit_q | run_hit;
          dir_d = dir_q + 2'd1;
          if (dir_q == 2'd3) begin
            // A win on the last free cell takes precedence over the draw.
            if (hit_q | run_hit) begin
              if (player_q) p2won_d = 1'b1;
              else          p1won_d = 1'b1;
              state_d = ST_OVER;
            end else if (moves_q == CW'(CELLS)) begin
              draw_d  = 1'b1;
              state_d = ST_OVER;
            end else begin
              player_d = ~player_q;
              state_d  = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      row_q     <= CENTER;
      col_q     <= CENTER;
      pr_q      <= '0;
      pc_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      player_q  <= 1'b0;
      moved_q   <= 1'b0;
      invalid_q <= 1'b0;
      p1won_q   <= 1'b0;
      p2won_q   <= 1'b0;
      draw_q    <= 1'b0;
      hit_q     <= 1'b0;
      dir_q     <= 2'd0;
      moves_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      player_q  <= player_d;
      moved_q   <= moved_d;
      invalid_q <= invalid_d;
      p1won_q   <= p1won_d;
      p2won_q   <= p2won_d;
      draw_q    <= draw_d;
      hit_q     <= hit_d;
      dir_q     <= dir_d;
      moves_q   <= moves_d;
    end
  end

  assign I           = cur_idx;
  assign P1          = p1_q;
  assign P2          = p2_q;
  assign Player      = player_q;
  assign PlayerMoved = moved_q;
  assign Invalid     = invalid_q;
  assign Busy        = (state_q == ST_CHECK);
  assign P1Won       = p1won_q;
  assign P2Won       = p2won_q;
  assign Draw        = draw_q;
  assign MoveCount   = moves_q;

endmodule
